interp_seq: RTL and testbench

Sequencer for the polyphase interpolator datapath. It accepts input samples over a valid/ready handshake and drives the interpolator's clock-enable, sample and phase inputs: UPFACTOR output phases per input sample. At end of frame it injects the zero samples needed to flush the FIR tail. It tags the interpolator's output stream with valid/last flags aligned to the datapath latency. Everything runs in the single fast (output-rate) clock domain, so no slow clock is needed.

---
 rtl/interp_seq_pkg.sv | 26 ++
 rtl/interp_seq_if.sv | 25 ++
 rtl/interp_seq_dly.sv | 29 ++
 rtl/interp_seq.sv | 148 ++++++++++++++
 tb/tb_interp_seq.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/interp_seq_pkg.sv
// Shared types and sizing helpers for the polyphase interpolator sequencer.
package interp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } interp_seq_state_t;

    localparam int PHW_MIN = 1;

    // Zero samples needed after the last real sample to push it through every tap.
    function automatic int flush_count(input int ntaps, input int upfactor);
        return (ntaps / upfactor) - 1;
    endfunction

    function automatic int phase_width(input int upfactor);
        return (upfactor <= 2) ? PHW_MIN : $clog2(upfactor);
    endfunction

    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/interp_seq_if.sv
// Sample stream into the sequencer and drive/tag signals toward the interpolator.
interface interp_seq_if #(
    parameter int IW  = 16,
    parameter int PHW = 3
);
    logic                  s_valid;
    logic                  s_ready;
    logic signed [IW-1:0]  s_data;
    logic                  s_last;
    logic                  o_ce;
    logic signed [IW-1:0]  o_sample;
    logic [PHW-1:0]        o_phase;
    logic                  m_valid;
    logic                  m_last;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, o_ce, o_sample, o_phase, m_valid, m_last
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, o_ce, o_sample, o_phase, m_valid, m_last
    );
endinterface

// File: rtl/interp_seq_dly.sv
// Free-running shift register that realigns the valid/last tags with the datapath latency.
module interp_seq_dly #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_valid,
    input  logic d_last,
    output logic q_valid,
    output logic q_last
);
    logic [1:0] pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= {d_valid, d_last};
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q_valid = pipe[DEPTH-1][1];
    assign q_last  = pipe[DEPTH-1][0];
endmodule

// File: rtl/interp_seq.sv
// Polyphase interpolator sequencer: phases, FIR tail flush and output tagging.
// Optional INTERP_SEQ_UNDERRUN_CNT_EN adds a saturating underrun-stall counter port.
module interp_seq
    import interp_pkg::*;
#(
    parameter int UPFACTOR = 5,
    parameter int NTAPS    = 30,
    parameter int IW       = 16,
    parameter int LATENCY  = 3
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    interp_seq_if.slave bus,
    output logic        o_busy,
    output logic        o_done
`ifdef INTERP_SEQ_UNDERRUN_CNT_EN
    ,
    output logic [15:0] o_underrun_cnt
`endif
);
    localparam int F   = flush_count(NTAPS, UPFACTOR);
    localparam int PHW = phase_width(UPFACTOR);
    localparam int FCW = count_width(F);
    localparam int DCW = count_width(LATENCY);
    localparam logic [PHW-1:0] LAST_PH = PHW'(UPFACTOR - 1);

    if ((NTAPS % UPFACTOR) != 0 || UPFACTOR < 2 || LATENCY < 1) begin : g_cfg_check
        $error("interp_seq: invalid UPFACTOR/NTAPS/LATENCY combination");
    end

    interp_seq_state_t    state, next;
    logic                 ce;
    logic signed [IW-1:0] sample;
    logic [PHW-1:0]       phase;
    logic [FCW-1:0]       flush_left;
    logic [DCW-1:0]       drain_cnt;
    logic                 done;
    logic                 ready, hs, phase_end, final_phase;

    assign ready       = (state == RUN) && (!ce || phase == LAST_PH);
    assign hs          = bus.s_valid && ready;
    assign phase_end   = ce && (phase == LAST_PH);
    assign final_phase = (state == FLUSH) && phase_end && (flush_left == '0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (i_start) next = RUN;
            RUN:     if (hs && bus.s_last) next = FLUSH;
            FLUSH:   if (final_phase) next = DRAIN;
            DRAIN:   if (drain_cnt == DCW'(LATENCY - 1)) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // FLUSH first finishes the last real sample's phases, then reloads zeros back to back.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ce         <= 1'b0;
            sample     <= '0;
            phase      <= '0;
            flush_left <= '0;
            drain_cnt  <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    if (hs) begin
                        sample     <= bus.s_data;
                        ce         <= 1'b1;
                        phase      <= '0;
                        flush_left <= FCW'(F);
                    end else if (phase_end) begin
                        ce <= 1'b0;
                    end else if (ce) begin
                        phase <= phase + PHW'(1);
                    end
                end
                FLUSH: begin
                    if (phase_end) begin
                        if (flush_left == '0) begin
                            ce <= 1'b0;
                        end else begin
                            sample     <= '0;
                            phase      <= '0;
                            flush_left <= flush_left - FCW'(1);
                        end
                    end else if (ce) begin
                        phase <= phase + PHW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DCW'(LATENCY - 1)) begin
                        drain_cnt <= '0;
                        done      <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                default: ce <= 1'b0;
            endcase
        end
    end

`ifdef INTERP_SEQ_UNDERRUN_CNT_EN
    logic        started;
    logic [15:0] urun;

    // Idle cycles before the first sample of a frame are not underruns.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            started <= 1'b0;
            urun    <= '0;
        end else if (state == IDLE && i_start) begin
            started <= 1'b0;
            urun    <= '0;
        end else begin
            if (hs) started <= 1'b1;
            if (state == RUN && !ce && started && urun != 16'hFFFF) urun <= urun + 16'd1;
        end
    end

    assign o_underrun_cnt = urun;
`endif

    interp_seq_dly #(.DEPTH(LATENCY)) u_dly (
        .clk     (i_clk),
        .rst_n   (i_reset_n),
        .d_valid (ce),
        .d_last  (final_phase),
        .q_valid (bus.m_valid),
        .q_last  (bus.m_last)
    );

    assign bus.s_ready  = ready;
    assign bus.o_ce     = ce;
    assign bus.o_sample = sample;
    assign bus.o_phase  = phase;
    assign o_busy       = (state != IDLE);
    assign o_done       = done;
endmodule

// File: tb/tb_interp_seq.sv
// Directed bench for interp_seq: table of frames plus reset, ignored-input and long random-stall runs.
module tb_interp_seq;
    localparam int UF  = 5;
    localparam int NT  = 30;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done;
`ifdef INTERP_SEQ_UNDERRUN_CNT_EN
    logic [15:0] urun;
`endif

    interp_seq_if #(.IW(16), .PHW(3)) bus ();

    interp_seq #(.UPFACTOR(UF), .NTAPS(NT), .IW(16), .LATENCY(LAT)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_start   (start),
        .bus       (bus),
        .o_busy    (busy),
        .o_done    (done)
`ifdef INTERP_SEQ_UNDERRUN_CNT_EN
        ,
        .o_underrun_cnt (urun)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Passive monitor sampling on the falling edge.
    bit          mon_en = 1'b0;
    int          cyc, mv_cnt, ml_cnt, done_cnt, first_mv, last_mv, ml_cyc, done_cyc, hold_err;
    logic [15:0] ce_smp[$];
    int          ce_ph[$];
    int          ce_cyc[$];
    logic [15:0] last_smp;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (bus.o_ce) begin
                ce_smp.push_back(bus.o_sample);
                ce_ph.push_back(int'(bus.o_phase));
                ce_cyc.push_back(cyc);
                last_smp = bus.o_sample;
            end else if (busy && ce_cyc.size() > 0 && bus.o_sample !== last_smp) begin
                hold_err++;
            end
            if (bus.m_valid) begin
                if (mv_cnt == 0) first_mv = cyc;
                mv_cnt++;
                last_mv = cyc;
            end
            if (bus.m_last) begin
                ml_cnt++;
                ml_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_mon();
        #1;
        cyc = 0; mv_cnt = 0; ml_cnt = 0; done_cnt = 0;
        first_mv = -1; last_mv = -1; ml_cyc = -1; done_cyc = -1; hold_err = 0;
        last_smp = '0;
        ce_smp.delete(); ce_ph.delete(); ce_cyc.delete();
    endtask

    task automatic send_sample(input logic [15:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        for (int t = 0; t < 100; t++) begin
            if (bus.s_ready === 1'b1) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_output("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply_stimulus(input int n, input int stall_at, input int stall_len,
                                  input bit mid_start, input bit random_stall, input bit ramp_data);
        bit seen;
        clear_mon();
        mon_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (random_stall && $urandom_range(0, 3) == 0) begin
                bus.s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            if (mid_start && i == 1) start = 1'b1;
            send_sample(ramp_data ? 16'(i) : 16'(16'h0100 * (i + 1)), (i == n - 1));
            start = 1'b0;
            if (i + 1 == stall_at) begin
                bus.s_valid = 1'b0;
                for (int t = 0; t < 20 && bus.s_ready !== 1'b1; t++) @(negedge clk);
                repeat (stall_len) @(negedge clk);
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_output("done_timeout", 32'd0, 32'd1);
        repeat (LAT + 2) @(negedge clk);
        mon_en = 1'b0;
    endtask

    typedef struct {
        int n;
        int stall_at;
        int stall_len;
        bit mid_start;
        int exp_ce;
        int exp_time;
    } frame_vec_t;

    frame_vec_t vecs[4];

    initial begin
        int errs, first_ce, span, rdy_hi;

        vecs[0] = '{n: 3, stall_at: 0, stall_len: 0, mid_start: 1'b0, exp_ce: 40, exp_time: 44};
        vecs[1] = '{n: 1, stall_at: 0, stall_len: 0, mid_start: 1'b0, exp_ce: 30, exp_time: 34};
        vecs[2] = '{n: 4, stall_at: 2, stall_len: 7, mid_start: 1'b0, exp_ce: 45, exp_time: 56};
        vecs[3] = '{n: 2, stall_at: 0, stall_len: 0, mid_start: 1'b1, exp_ce: 35, exp_time: 39};

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;

        repeat (3) @(negedge clk);
        check_output("reset_ce", 32'(bus.o_ce), 32'd0);
        check_output("reset_sample", 32'(bus.o_sample), 32'd0);
        check_output("reset_phase", 32'(bus.o_phase), 32'd0);
        check_output("reset_flags", {28'd0, bus.m_valid, bus.m_last, busy, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("idle_ready", 32'(bus.s_ready), 32'd0);

        // s_valid in IDLE must not be accepted.
        rdy_hi = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h1234;
        repeat (4) begin
            @(negedge clk);
            if (bus.s_ready !== 1'b0) rdy_hi++;
        end
        check_output("idle_no_ready", 32'(rdy_hi), 32'd0);
        check_output("idle_no_ce", {30'd0, bus.o_ce, busy}, 32'd0);
        bus.s_valid = 1'b0;

        // Reset asserted in the middle of FLUSH.
        clear_mon();
        mon_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_sample(16'h0100, 1'b0);
        send_sample(16'h0200, 1'b1);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        repeat (12) @(negedge clk);
        check_output("flush_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_rst_ce", 32'(bus.o_ce), 32'd0);
        check_output("async_rst_sample", 32'(bus.o_sample), 32'd0);
        check_output("async_rst_phase", 32'(bus.o_phase), 32'd0);
        check_output("async_rst_flags", {27'd0, bus.m_valid, bus.m_last, busy, done, bus.s_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (10) @(negedge clk);
        check_output("post_rst_mvalid", 32'(mv_cnt), 32'd0);
        check_output("post_rst_mlast", 32'(ml_cnt), 32'd0);
        mon_en = 1'b0;

        for (int v = 0; v < 4; v++) begin
            apply_stimulus(vecs[v].n, vecs[v].stall_at, vecs[v].stall_len, vecs[v].mid_start, 1'b0, 1'b0);
            first_ce = (ce_cyc.size() > 0) ? ce_cyc[0] : -1000;
            span     = (ce_cyc.size() > 0) ? (ce_cyc[ce_cyc.size()-1] - first_ce + 1) : 0;
            errs = 0;
            for (int j = 0; j < ce_smp.size(); j++) begin
                logic [15:0] es;
                es = ((j / UF) < vecs[v].n) ? 16'(16'h0100 * ((j / UF) + 1)) : 16'h0000;
                if (ce_smp[j] !== es || ce_ph[j] != (j % UF)) begin
                    if (errs == 0)
                        $display("[TB] vec%0d ce#%0d sample=0x%0h phase=%0d want 0x%0h/%0d",
                                 v, j, ce_smp[j], ce_ph[j], es, j % UF);
                    errs++;
                end
            end
            check_output($sformatf("v%0d_ce_count", v), 32'(ce_smp.size()), 32'(vecs[v].exp_ce));
            check_output($sformatf("v%0d_sample_phase", v), 32'(errs), 32'd0);
            check_output($sformatf("v%0d_gap", v), 32'(span - ce_smp.size()), 32'(vecs[v].stall_len));
            check_output($sformatf("v%0d_hold", v), 32'(hold_err), 32'd0);
            check_output($sformatf("v%0d_mvalid_count", v), 32'(mv_cnt), 32'(vecs[v].exp_ce));
            check_output($sformatf("v%0d_mvalid_align", v), 32'(first_mv), 32'(first_ce + LAT));
            check_output($sformatf("v%0d_mlast_count", v), 32'(ml_cnt), 32'd1);
            check_output($sformatf("v%0d_mlast_pos", v), 32'(ml_cyc), 32'(last_mv));
            check_output($sformatf("v%0d_done_count", v), 32'(done_cnt), 32'd1);
            check_output($sformatf("v%0d_done_pos", v), 32'(done_cyc), 32'(ml_cyc + 1));
            check_output($sformatf("v%0d_frame_time", v), 32'(done_cyc - first_ce + 1), 32'(vecs[v].exp_time));
`ifdef INTERP_SEQ_UNDERRUN_CNT_EN
            check_output($sformatf("v%0d_underrun", v), 32'(urun), 32'(vecs[v].stall_len));
`endif
        end

        // Long frame with random upstream stalls: (1000 + 5) * 5 outputs.
        apply_stimulus(1000, 0, 0, 1'b0, 1'b1, 1'b1);
        check_output("long_mvalid_count", 32'(mv_cnt), 32'd5025);
        check_output("long_mlast_count", 32'(ml_cnt), 32'd1);
        check_output("long_mlast_pos", 32'(ml_cyc), 32'(last_mv));
        check_output("long_done_count", 32'(done_cnt), 32'd1);
        check_output("long_idle_after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
